// File: rtl/vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vector_sequencer
// Purpose  : Host-side test-vector sequencer. Accepts vectors from a
//            valid/ready stream, writes {stim, cycles, mode} into the
//            stimulus FIFO, reads {result, cycle_count, timeout} back from
//            the result FIFO, compares each result against the expected
//            value queued for it and keeps pass/fail/timeout statistics
//            plus a first-failure capture.
// Ports    : clock, reset_n (async, active-low), start
//            vec_* : host vector stream (valid/ready)
//            sfifo_*: stimulus FIFO write side
//            rfifo_*: result FIFO read side (normal mode, 1-cycle latency)
//            busy/done, pass/fail/timeout counts, first_fail_*, underflow
// Revision : 1.0 - initial release
// ============================================================================
module vector_sequencer #(
  parameter int STF_WIDTH   = 24,
  parameter int RTF_WIDTH   = 24,
  parameter int CYCLE_RANGE = 5,
  parameter int EXP_DEPTH   = 16,
  parameter int EXP_AW      = 4
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic                             vec_valid,
  output logic                             vec_ready,
  input  logic [STF_WIDTH-1:0]             vec_stim,
  input  logic [CYCLE_RANGE-1:0]           vec_cycles,
  input  logic                             vec_mode,
  input  logic [RTF_WIDTH-1:0]             vec_expected,
  input  logic [RTF_WIDTH-1:0]             vec_mask,
  input  logic                             vec_last,
  output logic [STF_WIDTH+CYCLE_RANGE:0]   sfifo_data,
  output logic                             sfifo_wrreq,
  input  logic                             sfifo_wrfull,
  input  logic [RTF_WIDTH+CYCLE_RANGE:0]   rfifo_data,
  output logic                             rfifo_rdreq,
  input  logic                             rfifo_rdempty,
  output logic                             busy,
  output logic                             done,
  output logic [15:0]                      pass_count,
  output logic [15:0]                      fail_count,
  output logic [15:0]                      timeout_count,
  output logic                             first_fail_valid,
  output logic [15:0]                      first_fail_idx,
  output logic [RTF_WIDTH-1:0]             first_fail_result,
  output logic                             underflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [EXP_AW:0] c_exp_depth = (EXP_AW+1)'(EXP_DEPTH);

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_rd_pending;
  logic [15:0]              r_issued;
  logic [15:0]              r_retired;
  logic [15:0]              r_pass;
  logic [15:0]              r_fail;
  logic [15:0]              r_timeout;
  logic                     r_ff_valid;
  logic [15:0]              r_ff_idx;
  logic [RTF_WIDTH-1:0]     r_ff_result;
  logic                     r_underflow;

  // Expected queue: {expected, mask}. Pointers carry one extra wrap bit so
  // full and empty are distinguishable.
  logic [2*RTF_WIDTH-1:0]   r_exp_mem [EXP_DEPTH];
  logic [EXP_AW:0]          r_wptr;
  logic [EXP_AW:0]          r_rptr;

  logic                     w_run;
  logic                     w_active;
  logic                     w_exp_full;
  logic                     w_exp_empty;
  logic                     w_accept;
  logic                     w_start_take;
  logic [2*RTF_WIDTH-1:0]   w_head;
  logic [RTF_WIDTH-1:0]     w_head_exp;
  logic [RTF_WIDTH-1:0]     w_head_mask;
  logic [RTF_WIDTH-1:0]     w_result;
  logic                     w_timeout;
  logic [RTF_WIDTH-1:0]     w_mismatch;
  logic                     w_pass;
  logic [CYCLE_RANGE-1:0]   w_unused_cycles;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_run        = (r_state == S_RUN);
  assign w_active     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_exp_full   = ((r_wptr - r_rptr) == c_exp_depth);
  assign w_exp_empty  = (r_wptr == r_rptr);
  assign w_start_take = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign vec_ready    = w_run && !sfifo_wrfull && !w_exp_full;
  assign w_accept     = vec_valid && vec_ready;
  assign sfifo_wrreq  = w_accept;
  assign sfifo_data   = {vec_stim, vec_cycles, vec_mode};
  assign rfifo_rdreq  = w_active && !rfifo_rdempty;

  assign w_head       = r_exp_mem[r_rptr[EXP_AW-1:0]];
  assign w_head_exp   = w_head[2*RTF_WIDTH-1:RTF_WIDTH];
  assign w_head_mask  = w_head[RTF_WIDTH-1:0];

  // The cycle_count field only matters to the host, not to the compare.
  assign w_result        = rfifo_data[RTF_WIDTH+CYCLE_RANGE:CYCLE_RANGE+1];
  assign w_unused_cycles = rfifo_data[CYCLE_RANGE:1];
  assign w_timeout       = rfifo_data[0];
  assign w_mismatch      = (w_result ^ w_head_exp) & w_head_mask;
  assign w_pass          = (w_mismatch == '0) && !w_timeout;

  assign busy              = r_busy;
  assign done              = r_done;
  assign pass_count        = r_pass;
  assign fail_count        = r_fail;
  assign timeout_count     = r_timeout;
  assign first_fail_valid  = r_ff_valid;
  assign first_fail_idx    = r_ff_idx;
  assign first_fail_result = r_ff_result;
  assign underflow         = r_underflow;

  // Queue storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_exp_mem[r_wptr[EXP_AW-1:0]] <= {vec_expected, vec_mask};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rd_pending <= 1'b0;
      r_issued     <= '0;
      r_retired    <= '0;
      r_pass       <= '0;
      r_fail       <= '0;
      r_timeout    <= '0;
      r_ff_valid   <= 1'b0;
      r_ff_idx     <= '0;
      r_ff_result  <= '0;
      r_underflow  <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
    end else begin
      // Result FIFO is normal mode: data is on rfifo_data one cycle after rdreq.
      r_rd_pending <= rfifo_rdreq;

      if (w_start_take) begin
        r_state     <= S_RUN;
        r_busy      <= 1'b1;
        r_done      <= 1'b0;
        r_issued    <= '0;
        r_retired   <= '0;
        r_pass      <= '0;
        r_fail      <= '0;
        r_timeout   <= '0;
        r_ff_valid  <= 1'b0;
        r_ff_idx    <= '0;
        r_ff_result <= '0;
        r_underflow <= 1'b0;
        r_wptr      <= '0;
        r_rptr      <= '0;
      end else begin
        if (w_accept) begin
          r_wptr   <= r_wptr + 1'b1;
          r_issued <= r_issued + 16'd1;
        end

        if (r_rd_pending) begin
          if (w_exp_empty) begin
            // Result with nothing to compare against: flag and drop it.
            r_underflow <= 1'b1;
          end else begin
            r_rptr    <= r_rptr + 1'b1;
            r_retired <= r_retired + 16'd1;
            if (w_pass) begin
              r_pass <= sat_inc(r_pass);
            end else begin
              r_fail <= sat_inc(r_fail);
              if (!r_ff_valid) begin
                r_ff_valid  <= 1'b1;
                r_ff_idx    <= r_retired;
                r_ff_result <= w_result;
              end
            end
            if (w_timeout) begin
              r_timeout <= sat_inc(r_timeout);
            end
          end
        end

        case (r_state)
          S_RUN: begin
            if (w_accept && vec_last) begin
              r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if ((r_retired == r_issued) && !r_rd_pending) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/vector_sequencer.md
# vector_sequencer

Host-side counterpart of the DUT interface pipeline: accepts test vectors (stimulus, timing mode, expected response, compare mask) from a valid/ready stream. It writes the stimulus words into the stimulus FIFO consumed by the DUT interface, and reads the result FIFO that the DUT interface fills. Each result is compared against the expected value queued for it, and the block keeps pass/fail/timeout statistics plus a first-failure capture for the host.

## Interface
- STF_WIDTH, 24, stimulus vector width (DUT inputs)
- RTF_WIDTH, 24, result vector width (DUT outputs)
- CYCLE_RANGE, 5, width of cycle-count field
- EXP_DEPTH, 16, expected-value queue depth (power of two)
- EXP_AW, 4, log2(EXP_DEPTH)
- Reset: reset_n, asynchronous, active-low. Clock: clock.
- clock  in  1  system clock, same domain as both FIFO ports
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: clear statistics, begin a run
- vec_valid  in  1  host vector available
- vec_ready  out  1  vector accepted this cycle when high with vec_valid
- vec_stim  in  STF_WIDTH  stimulus data
- vec_cycles  in  CYCLE_RANGE  wait cycles / trigger timeout
- vec_mode  in  1  0 = fixed count, 1 = wait for trigger
- vec_expected  in  RTF_WIDTH  expected DUT response
- vec_mask  in  RTF_WIDTH  compare mask, 1 = bit checked
- vec_last  in  1  marks final vector of the run
- sfifo_data  out  STF_WIDTH+CYCLE_RANGE+1  {vec_stim, vec_cycles, vec_mode}
- sfifo_wrreq  out  1  stimulus FIFO write strobe
- sfifo_wrfull  in  1  stimulus FIFO full
- rfifo_data  in  RTF_WIDTH+CYCLE_RANGE+1  {result, cycle_count, timeout}
- rfifo_rdreq  out  1  result FIFO read strobe
- rfifo_rdempty  in  1  result FIFO empty
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- pass_count, fail_count, timeout_count  out  16 each  saturating statistics
- first_fail_valid  out  1  a failure has been captured this run
- first_fail_idx  out  16  index (from 0) of first failing vector
- first_fail_result  out  RTF_WIDTH  result field of first failing vector
- underflow  out  1  sticky: result arrived with expected queue empty

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on start, go to RUN.
- DONE: on start, go to RUN.
- RUN: on accept with vec_last = 1, go to DRAIN.
- DRAIN: when retired == issued and no read is in flight, go to DONE.
- start is ignored in RUN and DRAIN.
- On a start that is taken, in the same edge: clear all counters, first_fail_*, underflow, issued, retired, and the expected queue.
- vec_ready = (RUN) & ~sfifo_wrfull & ~exp_full. This term is combinational.
- sfifo_wrreq = vec_valid & vec_ready. sfifo_data is driven combinationally from the vec_* inputs.
- On accept:
  - push {vec_expected, vec_mask} into the expected queue;
  - issued++ (16-bit).
- rfifo_rdreq = (RUN | DRAIN) & ~rfifo_rdempty.
- The result FIFO is normal mode: data is valid the cycle after rdreq. A registered rd_pending flag marks the valid cycle.
- On rd_pending, pop the expected-queue head and compare.
  - Pass iff ((result ^ expected) & mask) == 0 and timeout == 0.
  - timeout = 1: counts as a fail and also increments timeout_count.
  - Failure with first_fail_valid = 0: capture retired into first_fail_idx and the result into first_fail_result, and set first_fail_valid.
  - Every compare does retired++.
- Empty queue on rd_pending: set underflow, discard the result, leave counts unchanged.
- The expected queue allows push and pop in the same cycle; occupancy is unchanged in that case.
- Counters saturate at 16'hFFFF.
- cycle_count in the result word is ignored for compare.

## Timing
- Reset values:
  - state IDLE;
  - vec_ready, sfifo_wrreq, rfifo_rdreq = 0;
  - busy, done = 0;
  - all counts 0;
  - first_fail_* = 0;
  - underflow = 0.
- Accept-to-FIFO-write latency is 0 cycles.
- Compare timing: rdreq at cycle T; data sampled at T+1; statistics updated at the T+1 edge and visible at T+2.
- Back-to-back reads are supported, one per cycle.
- done rises the cycle after the final statistics update.
- Reset mid-run aborts immediately to the reset values. FIFO contents are outside this block.

## Test plan
- Single vector, mode 0, cycles 3, expected 24'hA5A5A5, mask all-ones; matching result with timeout 0 → pass_count 1, fail_count 0, done, first_fail_valid 0.
- 20 vectors, result FIFO held non-empty only every third cycle → expected queue fills at 16 and vec_ready deasserts; all 20 retired in order; pass_count 20.
- Vector index 5 with bit 3 mismatched:
  - mask bit 3 = 0 → passes;
  - repeat with mask bit 3 = 1 → fail_count 1, first_fail_idx 5, first_fail_result equals the returned value.
- Mode 1 vector whose result has timeout = 1 and matching data → fail_count 1, timeout_count 1.
- sfifo_wrfull held high for 10 cycles mid-stream → no sfifo_wrreq, vec_ready 0; the stream resumes with no lost or duplicated vectors.
- Result word presented with no vector issued → underflow 1, counts 0.
- Reset asserted during DRAIN → all outputs return to reset values.
- start pulsed in RUN → ignored.
